// File: rtl/bch_syndrome.sv
// BCH receive-side syndrome generator: streams one codeword BITS per cycle and
// produces the odd syndromes S1..S(2T-1) over GF(2^M) with a held, handshaked output.

`ifndef BCH_PARAMS_SV
`define BCH_PARAMS_SV
// Packed parameter word: {M[7:0], T[7:0], DATA_BITS[15:0]}; ECC_BITS is taken as M*T.
`define BCH_PACK(m, t, k) ({8'(m), 8'(t), 16'(k)})
`define BCH_M(p) ((32'(p) >> 24) & 32'hff)
`define BCH_T(p) ((32'(p) >> 16) & 32'hff)
`define BCH_DATA_BITS(p) (32'(p) & 32'hffff)
`define BCH_ECC_BITS(p) (`BCH_M(p) * `BCH_T(p))
`define BCH_SANE `BCH_PACK(4, 2, 7)
`endif

// One syndrome lane: next accumulator value for S(ORD), constant-folded GF(2^M) math.
module bch_syn_lane #(
  parameter int M    = 4,
  parameter int BITS = 1,
  parameter int ORD  = 1,
  parameter int PAD  = 0,
  parameter int POLY = 'b10011
) (
  input  logic [M-1:0]    acc,
  input  logic [BITS-1:0] bits,
  input  logic            clear,
  input  logic            last,
  output logic [M-1:0]    nxt
);
  localparam logic [M-1:0] PLOW = POLY[M-1:0];
  localparam int           ORDER = (1 << M) - 1;

  function automatic logic [M-1:0] alpha_pow(int e);
    logic [M-1:0] v;
    v = M'(1);
    for (int n = 0; n < (e % ORDER); n++)
      v = v[M-1] ? ((v << 1) ^ PLOW) : (v << 1);
    return v;
  endfunction

  // Weight of in-cycle bit j when the lowest `shift` bits are pad.
  function automatic logic [BITS-1:0][M-1:0] bit_cols(int shift);
    logic [BITS-1:0][M-1:0] c;
    for (int j = 0; j < BITS; j++)
      c[j] = (j >= shift) ? alpha_pow(ORD * (j - shift)) : '0;
    return c;
  endfunction

  function automatic logic [M-1:0][M-1:0] mul_cols(int e);
    logic [M-1:0][M-1:0] c;
    for (int k = 0; k < M; k++) c[k] = alpha_pow(k + e);
    return c;
  endfunction

  // The final ECC cycle only advances by its real bits, so it gets its own tables.
  localparam logic [BITS-1:0][M-1:0] BC_N = bit_cols(0);
  localparam logic [BITS-1:0][M-1:0] BC_L = bit_cols(PAD);
  localparam logic [M-1:0][M-1:0]    MC_N = mul_cols(ORD * BITS);
  localparam logic [M-1:0][M-1:0]    MC_L = mul_cols(ORD * (BITS - PAD));

  always_comb begin
    nxt = '0;
    for (int k = 0; k < M; k++)
      if (!clear && acc[k]) nxt = nxt ^ (last ? MC_L[k] : MC_N[k]);
    for (int j = 0; j < BITS; j++)
      if (bits[j]) nxt = nxt ^ (last ? BC_L[j] : BC_N[j]);
  end
endmodule

module bch_syndrome #(
  parameter logic [31:0] P    = `BCH_SANE,
  parameter int          BITS = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                ready,
  input  logic [BITS-1:0]                     data_in,
  output logic                                syn_valid,
  input  logic                                syn_accepted,
  output logic [`BCH_T(P)*`BCH_M(P)-1:0]      syndromes,
  output logic                                err_present,
  output logic                                busy
);
  localparam int M           = `BCH_M(P);
  localparam int T           = `BCH_T(P);
  localparam int DATA_BITS   = `BCH_DATA_BITS(P);
  localparam int ECC_BITS    = `BCH_ECC_BITS(P);
  localparam int DATA_CYCLES = (DATA_BITS + BITS - 1) / BITS;
  localparam int ECC_CYCLES  = (ECC_BITS + BITS - 1) / BITS;
  localparam int CODE_CYCLES = DATA_CYCLES + ECC_CYCLES;
  localparam int REM         = DATA_BITS % BITS;
  localparam int EPAD        = ECC_CYCLES * BITS - ECC_BITS;
  localparam int CW          = $clog2(CODE_CYCLES + 1);

  function automatic int prim_poly(int m);
    case (m)
      3:       return 'b1011;
      4:       return 'b10011;
      5:       return 'b100101;
      6:       return 'b1000011;
      7:       return 'b10001001;
      8:       return 'b100011101;
      9:       return 'b1000010001;
      10:      return 'b10000001001;
      default: return 0;
    endcase
  endfunction

  localparam int POLY = prim_poly(M);
  localparam logic [BITS-1:0] FIRST_MASK =
    (REM == 0) ? {BITS{1'b1}} : BITS'((64'd1 << REM) - 64'd1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cyc;
  logic [T-1:0][M-1:0]    acc_q, acc_d, acc_nxt, syn_q, syn_d;
  logic                   syn_valid_q, syn_valid_d, err_q, err_d;
  logic                   ready_q, ready_d, busy_q, busy_d;
  logic                   xfer, last, out_free;
  logic [BITS-1:0]        bits_in;

  // A start always begins cycle 0, whether from IDLE or as an abort in ACCUM.
  assign xfer     = in_valid && ready_q;
  assign cyc      = start ? '0 : cnt_q;
  assign last     = (cyc == CW'(CODE_CYCLES - 1));
  assign bits_in  = data_in & (start ? FIRST_MASK : {BITS{1'b1}});
  assign out_free = !syn_valid_q || syn_accepted;

  for (genvar i = 0; i < T; i++) begin : g_lane
    bch_syn_lane #(.M(M), .BITS(BITS), .ORD(2 * i + 1), .PAD(EPAD), .POLY(POLY)) u_lane (
      .acc(acc_q[i]), .bits(bits_in), .clear(start), .last(last), .nxt(acc_nxt[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    syn_d       = syn_q;
    syn_valid_d = syn_valid_q && !syn_accepted;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer && (start || state_q == ACCUM)) begin
          acc_d = acc_nxt;
          cnt_d = cyc + CW'(1);
          if (!last) begin
            state_d = ACCUM;
          end else if (out_free) begin
            syn_d       = acc_nxt;
            syn_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (syn_accepted) begin
          syn_d       = acc_q;
          syn_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d   = |syn_d;
    ready_d = (state_d != HOLD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      syn_q       <= syn_d;
      syn_valid_q <= syn_valid_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign syndromes   = syn_q;
  assign err_present = err_q;
  assign syn_valid   = syn_valid_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_bch_syndrome.sv
// Bench for bch_syndrome on the (15,7,t=2) code with BITS=1, 3 and 4 side by side;
// expected syndromes come from evaluating the received polynomial at alpha and alpha^3.
module tb_bch_syndrome;
  logic       clk = 1'b0, rst = 1'b1;
  logic       vld [3], st [3], acc_in [3];
  logic [3:0] din [3];
  logic       rdy [3], sv [3], ep [3], bsy [3];
  logic [7:0] syn [3];
  int         mode [3];
  logic [8:0] expq [3][$];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  bch_syndrome #(.BITS(1)) u_b1 (.clk(clk), .reset(rst), .start(st[0]), .in_valid(vld[0]),
    .ready(rdy[0]), .data_in(din[0][0:0]), .syn_valid(sv[0]), .syn_accepted(acc_in[0]),
    .syndromes(syn[0]), .err_present(ep[0]), .busy(bsy[0]));
  bch_syndrome #(.BITS(3)) u_b3 (.clk(clk), .reset(rst), .start(st[1]), .in_valid(vld[1]),
    .ready(rdy[1]), .data_in(din[1][2:0]), .syn_valid(sv[1]), .syn_accepted(acc_in[1]),
    .syndromes(syn[1]), .err_present(ep[1]), .busy(bsy[1]));
  bch_syndrome #(.BITS(4)) u_b4 (.clk(clk), .reset(rst), .start(st[2]), .in_valid(vld[2]),
    .ready(rdy[2]), .data_in(din[2]), .syn_valid(sv[2]), .syn_accepted(acc_in[2]),
    .syndromes(syn[2]), .err_present(ep[2]), .busy(bsy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // alpha^e in GF(16) with x^4+x+1
  function automatic logic [3:0] gf_exp(input int e);
    logic [3:0] v = 4'b0001;
    for (int n = 0; n < e % 15; n++) v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
    return v;
  endfunction

  // {S3, S1} = {r(alpha^3), r(alpha)}
  function automatic logic [7:0] model_syn(input logic [14:0] cw);
    logic [3:0] s1 = '0, s3 = '0;
    for (int d = 0; d < 15; d++)
      if (cw[d]) begin
        s1 ^= gf_exp(d);
        s3 ^= gf_exp(3 * d);
      end
    return {s3, s1};
  endfunction

  function automatic int bw(input int id);
    return (id == 0) ? 1 : (id == 1) ? 3 : 4;
  endfunction

  function automatic logic [8:0] dexp(input logic [14:0] cw);
    logic [7:0] s = model_syn(cw);
    return {s != 8'h00, s};
  endfunction

  // Consumer: 0 = never accept, 1 = always accept, 2 = random.
  always @(posedge clk) begin
    #2;
    for (int id = 0; id < 3; id++)
      acc_in[id] = (mode[id] == 2) ? 1'($urandom_range(1)) : (mode[id] == 1);
  end

  always @(negedge clk) begin
    if (!rst)
      for (int id = 0; id < 3; id++)
        if (sv[id]) begin
          if (expq[id].size() == 0) check($sformatf("unexpected_set%0d", id), 1, 0);
          else begin
            check($sformatf("syn%0d", id), syn[id], expq[id][0][7:0]);
            check($sformatf("err_present%0d", id), ep[id], expq[id][0][8]);
          end
        end
  end

  always @(posedge clk) begin
    if (!rst)
      for (int id = 0; id < 3; id++)
        if (sv[id] && acc_in[id] && expq[id].size() > 0) void'(expq[id].pop_front());
  end

  task automatic wait_xfer(input int id);
    int  n = 0;
    bit  took;
    do begin
      took = rdy[id];
      @(posedge clk); #1;
      n++;
    end while (!took && n < 300);
    if (!took) check($sformatf("xfer_timeout%0d", id), 0, 1);
  endtask

  task automatic send_cw(input int id, input logic [14:0] cw, input bit pad1, input int gap_pct,
                         input int ncyc, input logic [8:0] expv);
    int   b, runt, epad, cc;
    logic q[$];
    b    = bw(id);
    runt = (7 % b == 0) ? 0 : b - 7 % b;
    epad = ((8 + b - 1) / b) * b - 8;
    cc   = (7 + b - 1) / b + (8 + b - 1) / b;
    for (int p = 0; p < runt; p++) q.push_back(pad1);
    for (int d = 14; d >= 0; d--) q.push_back(cw[d]);
    for (int p = 0; p < epad; p++) q.push_back(pad1);
    for (int c = 0; c < ncyc && c < cc; c++) begin
      while ($urandom_range(99) < gap_pct) begin
        vld[id] = 1'b0; st[id] = 1'($urandom_range(1)); din[id] = 4'($urandom);
        @(posedge clk); #1;
      end
      vld[id] = 1'b1; st[id] = (c == 0); din[id] = '0;
      for (int k = 0; k < b; k++) din[id][b-1-k] = q[c*b+k];
      wait_xfer(id);
    end
    vld[id] = 1'b0; st[id] = 1'b0;
    if (ncyc >= cc) expq[id].push_back(expv);
  endtask

  task automatic rand_words(input int id, input int n);
    logic [14:0] cw;
    int          k, p0, p1;
    for (int w = 0; w < n; w++) begin
      case ($urandom_range(3))
        0:       cw = 15'h0000;
        1:       cw = 15'h5370;
        2:       cw = 15'h7fff;
        default: cw = 15'h2c8f;
      endcase
      k  = $urandom_range(2);
      p0 = $urandom_range(14);
      p1 = (p0 + 1 + $urandom_range(13)) % 15;
      if (k >= 1) cw[p0] = ~cw[p0];
      if (k == 2) cw[p1] = ~cw[p1];
      send_cw(id, cw, 1'($urandom_range(1)), 50, 99, {k > 0, model_syn(cw)});
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int id = 0; id < 3; id++) begin
      vld[id] = 1'b0; st[id] = 1'b0; din[id] = '0; mode[id] = 1;
    end
    rst = 1'b1;
    step(2);
    for (int id = 0; id < 3; id++) begin
      check($sformatf("rst_valid%0d", id), sv[id], 0);
      check($sformatf("rst_syn%0d", id), syn[id], 0);
      check($sformatf("rst_err%0d", id), ep[id], 0);
      check($sformatf("rst_busy%0d", id), bsy[id], 0);
      check($sformatf("rst_ready%0d", id), rdy[id], 1);
    end
    rst = 1'b0;
    step(1);

    // model pins: valid codeword, single errors at degree 3 and 0
    check("pin_codeword", model_syn(15'h5370), 8'h00);
    check("pin_deg3", model_syn(15'h0008), 8'ha8);
    check("pin_deg0", model_syn(15'h0001), 8'h11);

    // zero codeword: result must be valid the cycle after the last transfer
    send_cw(0, 15'h0000, 1'b0, 0, 99, dexp(15'h0000));
    check("latency_valid", sv[0], 1);
    check("zero_syn", syn[0], 8'h00);
    step(2);

    // encoded data 1010011, with pad bits forced high on the wide lanes
    for (int id = 0; id < 3; id++) begin
      send_cw(id, 15'h5370, 1'b1, 0, 99, dexp(15'h5370));
      check($sformatf("codeword_syn%0d", id), syn[id], 8'h00);
      check($sformatf("codeword_err%0d", id), ep[id], 0);
      step(2);
    end

    // single errors
    send_cw(0, 15'h0008, 1'b0, 0, 99, dexp(15'h0008));
    check("deg3_syn", syn[0], 8'ha8);
    check("deg3_err", ep[0], 1);
    step(2);
    for (int id = 0; id < 3; id++) begin
      send_cw(id, 15'h0001, 1'b1, 0, 99, dexp(15'h0001));
      check($sformatf("deg0_syn%0d", id), syn[id], 8'h11);
      step(2);
    end

    // back-to-back with a stalled consumer: second word waits in HOLD
    mode[0] = 0;
    step(1);
    send_cw(0, 15'h0008, 1'b0, 0, 99, dexp(15'h0008));
    send_cw(0, 15'h0001, 1'b0, 0, 99, dexp(15'h0001));
    check("hold_ready", rdy[0], 0);
    check("hold_busy", bsy[0], 1);
    step(3);
    check("hold_keeps_first", syn[0], 8'ha8);
    check("hold_ready_late", rdy[0], 0);
    mode[0] = 1;
    step(1);
    check("handoff_valid", sv[0], 1);
    check("handoff_syn", syn[0], 8'h11);
    check("handoff_ready", rdy[0], 1);
    step(1);
    check("handoff_drained", sv[0], 0);
    check("handoff_queue", expq[0].size(), 0);

    // restart mid-codeword: only the second word may produce a set
    send_cw(0, 15'h0008, 1'b0, 0, 6, 9'h0);
    send_cw(0, 15'h0001, 1'b0, 0, 99, dexp(15'h0001));
    check("abort_syn", syn[0], 8'h11);
    step(2);

    // reset mid-codeword with a held result
    mode[0] = 0;
    step(1);
    send_cw(0, 15'h0008, 1'b0, 0, 99, dexp(15'h0008));
    send_cw(0, 15'h0001, 1'b0, 0, 6, 9'h0);
    rst = 1'b1;
    step(1);
    check("mid_rst_valid", sv[0], 0);
    check("mid_rst_syn", syn[0], 0);
    check("mid_rst_err", ep[0], 0);
    check("mid_rst_busy", bsy[0], 0);
    check("mid_rst_ready", rdy[0], 1);
    rst = 1'b0;
    for (int id = 0; id < 3; id++) expq[id].delete();
    mode[0] = 1;
    step(1);
    send_cw(0, 15'h0008, 1'b0, 0, 99, dexp(15'h0008));
    check("post_rst_syn", syn[0], 8'ha8);
    step(2);

    // random gaps, errors and consumer stalls on all three widths at once
    for (int id = 0; id < 3; id++) mode[id] = 2;
    fork
      rand_words(0, 20);
      rand_words(1, 20);
      rand_words(2, 20);
    join
    for (int id = 0; id < 3; id++) mode[id] = 1;
    step(6);
    for (int id = 0; id < 3; id++) check($sformatf("drain%0d", id), expq[id].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
